ddr3_app_arbiter: RTL and testbench

//  Two-port round-robin arbiter in front of the DDR3 controller user (app_*) interface.

---
 rtl/ddr3_app_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 controller app_* interface.
// Issues whole write/read bursts and routes in-order read data back to the issuing port.
module ddr3_app_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_MASK_WIDTH = 8,
    parameter     BURST_MODE     = "4",
    parameter int TAG_DEPTH      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      init_calib_complete,
    input  logic [1:0]                                req_valid,
    output logic [1:0]                                req_ready,
    input  logic [5:0]                                req_cmd,
    input  logic [2*ADDR_WIDTH-1:0]                   req_addr,
    input  logic [2*((BURST_MODE == "8") ? 2 : 1)*APP_DATA_WIDTH-1:0] req_wdata,
    input  logic [2*((BURST_MODE == "8") ? 2 : 1)*APP_MASK_WIDTH-1:0] req_wmask,
    input  logic                                      app_rdy,
    input  logic                                      app_wdf_rdy,
    input  logic                                      app_rd_data_valid,
    input  logic                                      app_rd_data_end,
    input  logic [APP_DATA_WIDTH-1:0]                 app_rd_data,
    output logic                                      app_en,
    output logic [2:0]                                app_cmd,
    output logic [ADDR_WIDTH-1:0]                     app_addr,
    output logic [APP_DATA_WIDTH-1:0]                 app_wdf_data,
    output logic [APP_MASK_WIDTH-1:0]                 app_wdf_mask,
    output logic                                      app_wdf_wren,
    output logic                                      app_wdf_end,
    output logic                                      app_burst,
    output logic [1:0]                                rd_valid,
    output logic                                      rd_end,
    output logic [APP_DATA_WIDTH-1:0]                 rd_data,
    output logic                                      busy,
    output logic                                      err
);

    localparam int BEATS = (BURST_MODE == "8") ? 2 : 1;
    localparam int DW    = APP_DATA_WIDTH;
    localparam int MW    = APP_MASK_WIDTH;
    localparam int PTR_W = $clog2(TAG_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CMD    = 2'd1;
    localparam logic [1:0] S_WBEAT2 = 2'd2;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(TAG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [1:0]            state_q, state_d;
    logic                  last_port_q, last_port_d;
    logic                  port_q, port_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEATS*DW-1:0]   wdata_q, wdata_d;
    logic [BEATS*MW-1:0]   wmask_q, wmask_d;

    logic                  tag_mem_q [TAG_DEPTH];
    logic                  tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  err_q, err_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            eligible;
    logic                  grant_port;
    logic                  push;
    logic                  pop;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    assign eligible[0] = req_valid[0] & init_calib_complete &
                         ((req_cmd[2:0] == CMD_WRITE) | ~fifo_full);
    assign eligible[1] = req_valid[1] & init_calib_complete &
                         ((req_cmd[5:3] == CMD_WRITE) | ~fifo_full);

    // With both ports eligible, the port that was not granted last wins.
    assign grant_port = (eligible == 2'b11) ? ~last_port_q : eligible[1];

    assign push = (state_q == S_CMD) && (cmd_q == CMD_READ) && app_rdy;

    always_comb begin
        state_d     = state_q;
        last_port_d = last_port_q;
        port_d      = port_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        req_ready   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d     = S_CMD;
                    last_port_d = grant_port;
                    port_d      = grant_port;
                    req_ready   = grant_port ? 2'b10 : 2'b01;
                    cmd_d       = grant_port ? req_cmd[5:3] : req_cmd[2:0];
                    addr_d      = grant_port ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                             : req_addr[ADDR_WIDTH-1:0];
                    wdata_d     = grant_port ? req_wdata[2*BEATS*DW-1:BEATS*DW]
                                             : req_wdata[BEATS*DW-1:0];
                    wmask_d     = grant_port ? req_wmask[2*BEATS*MW-1:BEATS*MW]
                                             : req_wmask[BEATS*MW-1:0];
                end
            end
            S_CMD: begin
                if (cmd_q == CMD_WRITE) begin
                    if (app_rdy && app_wdf_rdy) begin
                        state_d = (BEATS == 1) ? S_IDLE : S_WBEAT2;
                    end
                end else if (app_rdy) begin
                    state_d = S_IDLE;
                end
            end
            S_WBEAT2: begin
                if (app_wdf_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        case (state_q)
            S_CMD: begin
                app_en   = 1'b1;
                app_cmd  = cmd_q;
                app_addr = addr_q;
                if (cmd_q == CMD_WRITE) begin
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = (BEATS == 1);
                    app_wdf_data = wdata_q[DW-1:0];
                    app_wdf_mask = wmask_q[MW-1:0];
                end
            end
            S_WBEAT2: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_wdf_data = wdata_q[BEATS*DW-1 -: DW];
                app_wdf_mask = wmask_q[BEATS*MW-1 -: MW];
            end
            default: ;
        endcase
    end

    // Read data is returned in issue order, so the FIFO head names its owner.
    always_comb begin
        rd_valid = 2'b00;
        if (app_rd_data_valid && !fifo_empty) begin
            rd_valid = tag_mem_q[rd_ptr_q] ? 2'b10 : 2'b01;
        end
    end

    assign rd_end  = (|rd_valid) & ((BEATS == 1) | app_rd_data_end);
    assign pop     = rd_end;
    assign rd_data = app_rd_data;

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | (app_rd_data_valid & fifo_empty);
        if (push) begin
            tag_mem_d[wr_ptr_q] = port_q;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_port_q <= 1'b1;
            port_q      <= 1'b0;
            cmd_q       <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            tag_mem_q   <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_port_q <= last_port_d;
            port_q      <= port_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            tag_mem_q   <= tag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign app_burst = 1'b0;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed bench for ddr3_app_arbiter: one BL4 and one BL8 instance share the same
// command and return stimulus; each test checks the instance it targets.
module tb_ddr3_app_arbiter;

    localparam int AW = 28;
    localparam int DW = 64;
    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            calib;
    logic [1:0]      req_valid;
    logic [5:0]      req_cmd;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] wdata4;
    logic [2*MW-1:0] wmask4;
    logic [4*DW-1:0] wdata8;
    logic [4*MW-1:0] wmask8;
    logic            app_rdy;
    logic            app_wdf_rdy;
    logic            app_rd_data_valid;
    logic            app_rd_data_end;
    logic [DW-1:0]   app_rd_data;

    logic [1:0]    o4_req_ready, o8_req_ready;
    logic          o4_app_en, o8_app_en;
    logic [2:0]    o4_app_cmd, o8_app_cmd;
    logic [AW-1:0] o4_app_addr, o8_app_addr;
    logic [DW-1:0] o4_wdf_data, o8_wdf_data;
    logic [MW-1:0] o4_wdf_mask, o8_wdf_mask;
    logic          o4_wdf_wren, o8_wdf_wren;
    logic          o4_wdf_end, o8_wdf_end;
    logic          o4_burst, o8_burst;
    logic [1:0]    o4_rd_valid, o8_rd_valid;
    logic          o4_rd_end, o8_rd_end;
    logic [DW-1:0] o4_rd_data, o8_rd_data;
    logic          o4_busy, o8_busy;
    logic          o4_err, o8_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr3_app_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
                       .BURST_MODE("4"), .TAG_DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .init_calib_complete(calib),
        .req_valid(req_valid), .req_ready(o4_req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(wdata4), .req_wmask(wmask4),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_rd_data(app_rd_data),
        .app_en(o4_app_en), .app_cmd(o4_app_cmd), .app_addr(o4_app_addr),
        .app_wdf_data(o4_wdf_data), .app_wdf_mask(o4_wdf_mask),
        .app_wdf_wren(o4_wdf_wren), .app_wdf_end(o4_wdf_end), .app_burst(o4_burst),
        .rd_valid(o4_rd_valid), .rd_end(o4_rd_end), .rd_data(o4_rd_data),
        .busy(o4_busy), .err(o4_err)
    );

    ddr3_app_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
                       .BURST_MODE("8"), .TAG_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .init_calib_complete(calib),
        .req_valid(req_valid), .req_ready(o8_req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(wdata8), .req_wmask(wmask8),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_rd_data(app_rd_data),
        .app_en(o8_app_en), .app_cmd(o8_app_cmd), .app_addr(o8_app_addr),
        .app_wdf_data(o8_wdf_data), .app_wdf_mask(o8_wdf_mask),
        .app_wdf_wren(o8_wdf_wren), .app_wdf_end(o8_wdf_end), .app_burst(o8_burst),
        .rd_valid(o8_rd_valid), .rd_end(o8_rd_end), .rd_data(o8_rd_data),
        .busy(o8_busy), .err(o8_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [5:0] cmd,
                                 input logic [2*AW-1:0] addr);
        req_valid = valid;
        req_cmd   = cmd;
        req_addr  = addr;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst               = 1'b1;
        calib             = 1'b1;
        app_rdy           = 1'b0;
        app_wdf_rdy       = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        app_rd_data       = '0;
        applyStimulus(2'b00, 6'b000_000, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [DW-1:0] ret_data [3];
    logic [1:0]    ret_port [3];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        wdata4 = {64'h1111_2222_3333_4444, 64'hA5A5_0000_DEAD_BEEF};
        wmask4 = {8'hF0, 8'h0F};
        wdata8 = {64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000,
                  64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        wmask8 = {8'h81, 8'h80, 8'h01, 8'h00};
        ret_data = '{64'hD0D0_0000_0000_0000, 64'hD1D1_0000_0000_0001, 64'hD2D2_0000_0000_0002};
        ret_port = '{2'b01, 2'b10, 2'b01};

        // Reset values, sampled while rst is still high
        rst = 1'b1;
        calib = 1'b1;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = '0;
        applyStimulus(2'b00, 6'b000_000, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_app_en", o4_app_en, 1'b0);
        checkOutput("rst_req_ready", o4_req_ready, 2'b00);
        checkOutput("rst_busy", o4_busy, 1'b0);
        checkOutput("rst_err", o8_err, 1'b0);
        checkOutput("rst_wren", o8_wdf_wren, 1'b0);
        checkOutput("rst_rd_valid", o4_rd_valid, 2'b00);

        // BL4 single-beat write from port 0
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b01, 6'b000_000, {28'h0, 28'h10});
        #1;
        checkOutput("bl4_req_ready", o4_req_ready, 2'b01);
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        #1;
        checkOutput("bl4_app_en", o4_app_en, 1'b1);
        checkOutput("bl4_app_cmd", o4_app_cmd, 3'b000);
        checkOutput("bl4_app_addr", o4_app_addr, 28'h10);
        checkOutput("bl4_wren", o4_wdf_wren, 1'b1);
        checkOutput("bl4_wdf_end", o4_wdf_end, 1'b1);
        checkOutput("bl4_wdf_data", o4_wdf_data, 64'hA5A5_0000_DEAD_BEEF);
        checkOutput("bl4_wdf_mask", o4_wdf_mask, 8'h0F);
        checkOutput("bl4_burst", o4_burst, 1'b0);
        checkOutput("bl8_cmd_end_low", o8_wdf_end, 1'b0);
        stepClock();
        #1;
        checkOutput("bl4_done_en", o4_app_en, 1'b0);
        checkOutput("bl4_done_wren", o4_wdf_wren, 1'b0);
        checkOutput("bl4_done_busy", o4_busy, 1'b0);

        // Round-robin with both ports requesting continuously
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b11, 6'b000_000, {28'h0BB, 28'h0AA});
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("rr_ready_%0d", k), o4_req_ready,
                        (k % 2 == 0) ? 2'b01 : 2'b10);
            stepClock();
            #1;
            checkOutput($sformatf("rr_en_%0d", k), o4_app_en, 1'b1);
            checkOutput($sformatf("rr_addr_%0d", k), o4_app_addr,
                        (k % 2 == 0) ? 28'h0AA : 28'h0BB);
            stepClock();
        end
        applyStimulus(2'b00, 6'b000_000, '0);

        // BL8 write from port 1 with write-data stall in the second beat
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b10, 6'b000_000, {28'h200, 28'h0});
        #1;
        checkOutput("bl8_req_ready", o8_req_ready, 2'b10);
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        #1;
        checkOutput("bl8_cmd_en", o8_app_en, 1'b1);
        checkOutput("bl8_cmd_addr", o8_app_addr, 28'h200);
        checkOutput("bl8_beat0_data", o8_wdf_data, 64'hB0B0_B0B0_0000_0000);
        checkOutput("bl8_beat0_end", o8_wdf_end, 1'b0);
        stepClock();
        app_wdf_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("bl8_stall_en_%0d", k), o8_app_en, 1'b0);
            checkOutput($sformatf("bl8_stall_wren_%0d", k), o8_wdf_wren, 1'b1);
            checkOutput($sformatf("bl8_stall_end_%0d", k), o8_wdf_end, 1'b1);
            checkOutput($sformatf("bl8_stall_data_%0d", k), o8_wdf_data, 64'hB1B1_B1B1_0000_0001);
            checkOutput($sformatf("bl8_stall_mask_%0d", k), o8_wdf_mask, 8'h81);
            stepClock();
        end
        app_wdf_rdy = 1'b1;
        #1;
        checkOutput("bl8_release_wren", o8_wdf_wren, 1'b1);
        stepClock();
        #1;
        checkOutput("bl8_idle_wren", o8_wdf_wren, 1'b0);
        checkOutput("bl8_idle_busy", o8_busy, 1'b0);

        // Reads p0,p1,p0 and in-order return
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b11, 6'b001_001, {28'h300, 28'h100});
        #1;
        checkOutput("rd_grant_0", o4_req_ready, 2'b01);
        stepClock(); stepClock();
        #1;
        checkOutput("rd_grant_1", o4_req_ready, 2'b10);
        stepClock(); stepClock();
        #1;
        checkOutput("rd_grant_2", o4_req_ready, 2'b01);
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        stepClock();
        #1;
        checkOutput("rd_busy_pending", o4_busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data_end   = 1'b1;
            app_rd_data       = ret_data[k];
            #1;
            checkOutput($sformatf("rd_valid_%0d", k), o4_rd_valid, ret_port[k]);
            checkOutput($sformatf("rd_end_%0d", k), o4_rd_end, 1'b1);
            checkOutput($sformatf("rd_data_%0d", k), o4_rd_data, ret_data[k]);
            stepClock();
        end
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        #1;
        checkOutput("rd_busy_clear", o4_busy, 1'b0);
        checkOutput("rd_err_clear", o4_err, 1'b0);

        // Tag FIFO full: reads blocked, writes still granted
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b01, 6'b001_001, {28'h0, 28'h40});
        repeat (16) stepClock();
        #1;
        checkOutput("full_read_blocked", o4_req_ready, 2'b00);
        checkOutput("full_busy", o4_busy, 1'b1);
        applyStimulus(2'b11, 6'b000_001, {28'h500, 28'h40});
        #1;
        checkOutput("full_write_granted", o4_req_ready, 2'b10);
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        #1;
        checkOutput("full_write_en", o4_app_en, 1'b1);
        checkOutput("full_write_cmd", o4_app_cmd, 3'b000);
        checkOutput("full_write_addr", o4_app_addr, 28'h500);
        checkOutput("full_err", o4_err, 1'b0);

        // BL8 two-beat read return to port 1
        resetDut();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        applyStimulus(2'b10, 6'b001_000, {28'h600, 28'h0});
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        stepClock();
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b0; app_rd_data = 64'hC0;
        #1;
        checkOutput("bl8_rd_valid_b0", o8_rd_valid, 2'b10);
        checkOutput("bl8_rd_end_b0", o8_rd_end, 1'b0);
        stepClock();
        app_rd_data_end = 1'b1; app_rd_data = 64'hC1;
        #1;
        checkOutput("bl8_rd_valid_b1", o8_rd_valid, 2'b10);
        checkOutput("bl8_rd_end_b1", o8_rd_end, 1'b1);
        stepClock();
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        #1;
        checkOutput("bl8_rd_busy", o8_busy, 1'b0);
        checkOutput("bl8_rd_err", o8_err, 1'b0);

        // Read beat with empty tag FIFO
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        #1;
        checkOutput("orphan_rd_valid", o8_rd_valid, 2'b00);
        stepClock();
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        #1;
        checkOutput("orphan_err_set", o8_err, 1'b1);
        stepClock(); stepClock();
        #1;
        checkOutput("orphan_err_sticky", o8_err, 1'b1);

        // Calibration not complete blocks grants
        calib = 1'b0;
        applyStimulus(2'b01, 6'b000_000, {28'h0, 28'h700});
        #1;
        checkOutput("calib_no_grant", o8_req_ready, 2'b00);
        stepClock();
        #1;
        checkOutput("calib_no_en", o8_app_en, 1'b0);

        // Reset in the middle of the second write beat
        calib = 1'b1;
        #1;
        checkOutput("midrst_grant", o8_req_ready, 2'b01);
        stepClock();
        applyStimulus(2'b00, 6'b000_000, '0);
        stepClock();
        app_wdf_rdy = 1'b0;
        #1;
        checkOutput("midrst_in_wbeat2", o8_wdf_end, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wren", o8_wdf_wren, 1'b0);
        checkOutput("midrst_busy", o8_busy, 1'b0);
        checkOutput("midrst_err", o8_err, 1'b0);
        stepClock();
        rst = 1'b0;
        app_wdf_rdy = 1'b1;
        stepClock();
        #1;
        checkOutput("midrst_no_reissue", o8_wdf_wren, 1'b0);
        checkOutput("midrst_no_en", o8_app_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
